// File: rtl/c432_bist_ctrl.sv
// BIST controller for a c432-class CUT: LFSR pattern source
// and 16-bit MISR response compactor with golden compare.
module c432_bist_ctrl #(
  parameter int unsigned N_PATTERNS = 1024,
  parameter logic [35:0] SEED       = 36'h000000001,
  parameter logic [15:0] GOLDEN     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [35:0] cut_in,
  input  logic [6:0]  cut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] pat_count
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  // an all-zero seed would lock the LFSR
  localparam logic [35:0] SEED_EFF = (SEED == 36'h0) ? 36'h1 : SEED;
  localparam logic [15:0] N_LAST   = 16'(N_PATTERNS);

  state_t      state;
  logic [35:0] lfsr;
  logic [35:0] lfsr_nxt;
  logic [15:0] misr_nxt;
  logic [15:0] cnt_nxt;
  logic        last;

  always_comb begin
    lfsr_nxt = {lfsr[34:0], lfsr[35] ^ lfsr[24]};
    misr_nxt = {signature[14:0],
                signature[15] ^ signature[14] ^
                signature[12] ^ signature[3]}
             ^ {9'b0, cut_out};
    cnt_nxt  = pat_count + 16'd1;
    last     = (cnt_nxt == N_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= '0;
      cut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      pat_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state     <= APPLY;
            lfsr      <= SEED_EFF;
            cut_in    <= SEED_EFF;
            signature <= '0;
            pat_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        APPLY: begin
          if (abort) begin
            // signature and count stay frozen for debug
            state  <= IDLE;
            busy   <= 1'b0;
            cut_in <= '0;
          end else begin
            signature <= misr_nxt;
            lfsr      <= lfsr_nxt;
            pat_count <= cnt_nxt;
            if (last) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (misr_nxt == GOLDEN);
              cut_in <= '0;
            end else begin
              cut_in <= lfsr_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c432_bist_ctrl.sv
// Self-checking bench for c432_bist_ctrl: table-driven short runs,
// abort/restart sequences and long runs against a reference model.
module tb_c432_bist_ctrl;

  localparam logic [35:0] SEED_M = 36'h80F0F1234;
  localparam logic [35:0] SEED_C = 36'h5A5A50001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_s = 1'b0, abort_s = 1'b0;
  logic start_m = 1'b0, abort_m = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0;
  logic [6:0] co_s = 7'h01;
  logic [6:0] co_m, co_z, co_c, co_t;

  logic [35:0] ci_a, ci_b, ci_m, ci_z, ci_c, ci_t;
  logic bz_a, bz_b, bz_m, bz_z, bz_c, bz_t;
  logic dn_a, dn_b, dn_m, dn_z, dn_c, dn_t;
  logic ps_a, ps_b, ps_m, ps_z, ps_c, ps_t;
  logic [15:0] sg_a, sg_b, sg_m, sg_z, sg_c, sg_t;
  logic [15:0] pc_a, pc_b, pc_m, pc_z, pc_c, pc_t;

  function automatic logic [6:0] fclean(input logic [35:0] x);
    return {^x[35:31], ^x[30:26], x[25] & x[3], ^x[24:18],
            x[17] | x[9], ^x[16:8], ^x[7:0]};
  endfunction

  function automatic logic [6:0] ftroj(input logic [35:0] x);
    return fclean(x) ^ {6'b0, x[3:0] == 4'hA};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m,
                                            input logic [6:0] r);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {9'b0, r};
  endfunction

  function automatic logic [35:0] lfsr_step(input logic [35:0] l);
    return {l[34:0], l[35] ^ l[24]};
  endfunction

  function automatic logic [15:0] misr4(input logic [6:0] c);
    logic [15:0] m = '0;
    for (int i = 0; i < 4; i++) m = misr_step(m, c);
    return m;
  endfunction

  assign co_m = fclean(ci_m);
  assign co_z = 7'h00;
  assign co_c = fclean(ci_c);
  assign co_t = ftroj(ci_t);

  c432_bist_ctrl #(.N_PATTERNS(4), .SEED(36'h1), .GOLDEN(16'h000F)) u_a (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
    .cut_in(ci_a), .cut_out(co_s), .busy(bz_a), .done(dn_a),
    .pass(ps_a), .signature(sg_a), .pat_count(pc_a));

  c432_bist_ctrl #(.N_PATTERNS(4), .SEED(36'h1), .GOLDEN(16'h000E)) u_b (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
    .cut_in(ci_b), .cut_out(co_s), .busy(bz_b), .done(dn_b),
    .pass(ps_b), .signature(sg_b), .pat_count(pc_b));

  c432_bist_ctrl #(.N_PATTERNS(8), .SEED(SEED_M), .GOLDEN(16'h0000)) u_m (
    .clk(clk), .rst(rst), .start(start_m), .abort(abort_m),
    .cut_in(ci_m), .cut_out(co_m), .busy(bz_m), .done(dn_m),
    .pass(ps_m), .signature(sg_m), .pat_count(pc_m));

  c432_bist_ctrl #(.N_PATTERNS(1024), .SEED(36'h0), .GOLDEN(16'h0000)) u_z (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .cut_in(ci_z), .cut_out(co_z), .busy(bz_z), .done(dn_z),
    .pass(ps_z), .signature(sg_z), .pat_count(pc_z));

  c432_bist_ctrl #(.N_PATTERNS(1024), .SEED(SEED_C), .GOLDEN(16'h0000)) u_c (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .cut_in(ci_c), .cut_out(co_c), .busy(bz_c), .done(dn_c),
    .pass(ps_c), .signature(sg_c), .pat_count(pc_c));

  c432_bist_ctrl #(.N_PATTERNS(1024), .SEED(SEED_C), .GOLDEN(16'h0000)) u_t (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .cut_in(ci_t), .cut_out(co_t), .busy(bz_t), .done(dn_t),
    .pass(ps_t), .signature(sg_t), .pat_count(pc_t));

  int checks = 0;
  int failures = 0;
  logic [35:0] sbq[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string name, input logic [35:0] act);
    if (sbq.size() == 0) begin
      chk({name, "_underflow"}, 64'(1), 64'(0));
    end else begin
      chk(name, 64'(act), 64'(sbq.pop_front()));
    end
  endtask

  typedef struct {
    logic [6:0]  co;
    logic [15:0] sig;
    logic        pa;
    logic        pb;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [35:0] lf;
    logic [15:0] ms;
    logic [15:0] m8;
    logic [15:0] mc;
    logic [15:0] mt;
    int zeros;
    int cyc;

    tbl[0] = '{7'h01, 16'h000F, 1'b1, 1'b0};
    tbl[1] = '{7'h00, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{7'h7F, misr4(7'h7F), misr4(7'h7F) == 16'h000F,
               misr4(7'h7F) == 16'h000E};
    tbl[3] = '{7'h02, misr4(7'h02), misr4(7'h02) == 16'h000F,
               misr4(7'h02) == 16'h000E};

    // reset with start held high
    rst = 1'b1;
    start_s = 1'b1; start_m = 1'b1; start_b = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start_s = 1'b0; start_m = 1'b0; start_b = 1'b0;
    chk("rst_cut_in", 64'(ci_a), 64'(0));
    chk("rst_busy", 64'(bz_a), 64'(0));
    chk("rst_done", 64'(dn_a), 64'(0));
    chk("rst_pass", 64'(ps_a), 64'(0));
    chk("rst_sig", 64'(sg_a), 64'(0));
    chk("rst_cnt", 64'(pc_a), 64'(0));
    chk("rst_m_busy", 64'(bz_m), 64'(0));
    tick();
    chk("rst_idle_busy", 64'(bz_a), 64'(0));

    // table-driven 4-pattern runs; later rows restart from DONE
    for (int r = 0; r < 4; r++) begin
      co_s = tbl[r].co;
      start_s = 1'b1;
      lf = 36'h1;
      for (int k = 0; k < 4; k++) begin
        sbq.push_back(lf);
        lf = lfsr_step(lf);
      end
      tick();
      start_s = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t%0d_busy%0d", r, k), 64'(bz_a), 64'(1));
        pop_chk($sformatf("t%0d_cut_in%0d", r, k), ci_a);
        tick();
      end
      chk($sformatf("t%0d_busy_end", r), 64'(bz_a), 64'(0));
      chk($sformatf("t%0d_done", r), 64'(dn_a), 64'(1));
      chk($sformatf("t%0d_cnt", r), 64'(pc_a), 64'(4));
      chk($sformatf("t%0d_sig", r), 64'(sg_a), 64'(tbl[r].sig));
      chk($sformatf("t%0d_pass_a", r), 64'(ps_a), 64'(tbl[r].pa));
      chk($sformatf("t%0d_sig_b", r), 64'(sg_b), 64'(tbl[r].sig));
      chk($sformatf("t%0d_pass_b", r), 64'(ps_b), 64'(tbl[r].pb));
      chk($sformatf("t%0d_cut_in0", r), 64'(ci_a), 64'(0));
      tick();
      chk($sformatf("t%0d_hold_sig", r), 64'(sg_a), 64'(tbl[r].sig));
      chk($sformatf("t%0d_hold_done", r), 64'(dn_a), 64'(1));
    end

    // start ignored mid-run, abort after 3 absorbs
    lf = SEED_M; ms = '0;
    for (int k = 0; k < 3; k++) begin
      ms = misr_step(ms, fclean(lf));
      lf = lfsr_step(lf);
    end
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    chk("m_first_cut_in", 64'(ci_m), 64'(SEED_M));
    tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    chk("m_start_ignored", 64'(pc_m), 64'(2));
    tick();
    chk("m_cnt3", 64'(pc_m), 64'(3));
    abort_m = 1'b1;
    tick();
    abort_m = 1'b0;
    chk("abort_busy", 64'(bz_m), 64'(0));
    chk("abort_done", 64'(dn_m), 64'(0));
    chk("abort_pass", 64'(ps_m), 64'(0));
    chk("abort_cnt", 64'(pc_m), 64'(3));
    chk("abort_cut_in", 64'(ci_m), 64'(0));
    chk("abort_sig", 64'(sg_m), 64'(ms));

    start_m = 1'b1; abort_m = 1'b1;
    tick();
    start_m = 1'b0; abort_m = 1'b0;
    chk("idle_start_abort_busy", 64'(bz_m), 64'(0));
    chk("idle_start_abort_cnt", 64'(pc_m), 64'(3));

    // full 8-pattern run, abort in DONE, then restart
    lf = SEED_M; m8 = '0;
    for (int k = 0; k < 8; k++) begin
      m8 = misr_step(m8, fclean(lf));
      lf = lfsr_step(lf);
    end
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (8) tick();
    chk("m_done", 64'(dn_m), 64'(1));
    chk("m_sig", 64'(sg_m), 64'(m8));
    chk("m_cnt", 64'(pc_m), 64'(8));
    chk("m_pass", 64'(ps_m), 64'(m8 == 16'h0));
    abort_m = 1'b1;
    tick();
    abort_m = 1'b0;
    chk("done_abort_ignored", 64'(dn_m), 64'(1));
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    chk("restart_done_low", 64'(dn_m), 64'(0));
    chk("restart_busy", 64'(bz_m), 64'(1));
    chk("restart_cnt", 64'(pc_m), 64'(0));
    chk("restart_cut_in", 64'(ci_m), 64'(SEED_M));
    repeat (8) tick();
    chk("restart_sig", 64'(sg_m), 64'(m8));
    chk("restart_done", 64'(dn_m), 64'(1));

    // reset mid-run beats start
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    tick();
    tick();
    rst = 1'b1; start_m = 1'b1;
    tick();
    rst = 1'b0; start_m = 1'b0;
    chk("midrst_busy", 64'(bz_m), 64'(0));
    chk("midrst_cnt", 64'(pc_m), 64'(0));
    chk("midrst_sig", 64'(sg_m), 64'(0));
    chk("midrst_cut_in", 64'(ci_m), 64'(0));

    // long runs: zero seed, clean CUT, infected CUT
    lf = SEED_C; mc = '0; mt = '0;
    for (int k = 0; k < 1024; k++) begin
      sbq.push_back(lf);
      mc = misr_step(mc, fclean(lf));
      mt = misr_step(mt, ftroj(lf));
      lf = lfsr_step(lf);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("z_first_cut_in", 64'(ci_z), 64'(1));
    zeros = 0;
    cyc = 0;
    for (int i = 0; i < 1100 && bz_c; i++) begin
      pop_chk("c_cut_in", ci_c);
      if (ci_z == 36'h0) zeros++;
      cyc++;
      tick();
    end
    chk("big_done", 64'(dn_c), 64'(1));
    chk("big_busy_cycles", 64'(cyc), 64'(1024));
    chk("big_sb_empty", 64'(sbq.size()), 64'(0));
    chk("z_never_zero", 64'(zeros), 64'(0));
    chk("z_sig", 64'(sg_z), 64'(0));
    chk("z_done", 64'(dn_z), 64'(1));
    chk("z_pass", 64'(ps_z), 64'(1));
    chk("c_cnt", 64'(pc_c), 64'(1024));
    chk("c_sig", 64'(sg_c), 64'(mc));
    chk("t_sig", 64'(sg_t), 64'(mt));
    chk("troj_detect", 64'(sg_c != sg_t), 64'(mc != mt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
